// File: rtl/spi_reg_arbiter.sv
// Register bank shared between the SPI slave write port (buffered, unstallable strobes)
// and a core req/gnt port, with round-robin serialization of commits.
module spi_reg_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned REG_W  = 8,
  parameter int unsigned NREG   = 2**ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       spi_addr,
  input  logic [REG_W-1:0]        spi_wdata,
  input  logic                    spi_wvld,
  output logic [REG_W-1:0]        spi_rdata,
  input  logic                    core_req,
  input  logic                    core_we,
  input  logic [ADDR_W-1:0]       core_addr,
  input  logic [REG_W-1:0]        core_wdata,
  output logic                    core_gnt,
  output logic [REG_W-1:0]        core_rdata,
  output logic [NREG*REG_W-1:0]   regs_flat,
  output logic                    wr_evt,
  output logic                    wr_evt_src,
  output logic [ADDR_W-1:0]       wr_evt_addr,
  output logic                    spi_ovf,
  output logic                    busy
);

  localparam int unsigned FIFO_D = 2;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_CORE_ACK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [REG_W-1:0]   regs_q [NREG];
  logic [REG_W-1:0]   regs_d [NREG];
  logic [ADDR_W-1:0]  fifo_addr_q [FIFO_D];
  logic [ADDR_W-1:0]  fifo_addr_d [FIFO_D];
  logic [REG_W-1:0]   fifo_data_q [FIFO_D];
  logic [REG_W-1:0]   fifo_data_d [FIFO_D];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_core_q, last_core_d;
  logic [REG_W-1:0]   core_rdata_q, core_rdata_d;
  logic               wr_evt_q, wr_evt_d;
  logic               wr_evt_src_q, wr_evt_src_d;
  logic [ADDR_W-1:0]  wr_evt_addr_q, wr_evt_addr_d;
  logic               spi_ovf_q, spi_ovf_d;

  logic               spi_cand, core_cand, spi_win, core_win;
  logic               push, pop;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [REG_W-1:0]   wr_data;
  logic [REG_W-1:0]   core_rd_val;

  // Round robin: SPI wins a tie when the core committed last.
  assign spi_cand  = (cnt_q != CNT_W'(0));
  assign core_cand = (state_q == S_IDLE) && core_req;
  assign spi_win   = spi_cand && (!core_cand || last_core_q);
  assign core_win  = core_cand && !spi_win;
  assign pop       = spi_win;
  assign push      = spi_wvld && ((cnt_q != CNT_W'(FIFO_D)) || pop);

  // Read muxes; addresses outside the bank decode to nothing and read as 0.
  always_comb begin
    spi_rdata   = '0;
    core_rd_val = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (spi_addr == ADDR_W'(i))  spi_rdata   = regs_q[i];
      if (core_addr == ADDR_W'(i)) core_rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    last_core_d   = last_core_q;
    core_rdata_d  = core_rdata_q;
    wr_evt_d      = 1'b0;
    wr_evt_src_d  = wr_evt_src_q;
    wr_evt_addr_d = wr_evt_addr_q;
    spi_ovf_d     = spi_ovf_q;
    wr_en         = 1'b0;
    wr_addr       = fifo_addr_q[rd_ptr_q];
    wr_data       = fifo_data_q[rd_ptr_q];
    for (int i = 0; i < int'(FIFO_D); i++) begin
      fifo_addr_d[i] = fifo_addr_q[i];
      fifo_data_d[i] = fifo_data_q[i];
    end

    case (state_q)
      S_IDLE:     if (core_win) state_d = S_CORE_ACK;
      S_CORE_ACK: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (spi_win) begin
      wr_en         = 1'b1;
      wr_evt_d      = 1'b1;
      wr_evt_src_d  = 1'b0;
      wr_evt_addr_d = fifo_addr_q[rd_ptr_q];
      last_core_d   = 1'b0;
      rd_ptr_d      = ~rd_ptr_q;
    end

    if (core_win) begin
      last_core_d = 1'b1;
      if (core_we) begin
        wr_en         = 1'b1;
        wr_addr       = core_addr;
        wr_data       = core_wdata;
        wr_evt_d      = 1'b1;
        wr_evt_src_d  = 1'b1;
        wr_evt_addr_d = core_addr;
      end else begin
        core_rdata_d = core_rd_val;
      end
    end

    if (push) begin
      fifo_addr_d[wr_ptr_q] = spi_addr;
      fifo_data_d[wr_ptr_q] = spi_wdata;
      wr_ptr_d              = ~wr_ptr_q;
    end else if (spi_wvld) begin
      spi_ovf_d = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    for (int i = 0; i < int'(NREG); i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == ADDR_W'(i))) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      cnt_q         <= '0;
      last_core_q   <= 1'b1;
      core_rdata_q  <= '0;
      wr_evt_q      <= 1'b0;
      wr_evt_src_q  <= 1'b0;
      wr_evt_addr_q <= '0;
      spi_ovf_q     <= 1'b0;
      for (int i = 0; i < int'(FIFO_D); i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      last_core_q   <= last_core_d;
      core_rdata_q  <= core_rdata_d;
      wr_evt_q      <= wr_evt_d;
      wr_evt_src_q  <= wr_evt_src_d;
      wr_evt_addr_q <= wr_evt_addr_d;
      spi_ovf_q     <= spi_ovf_d;
      for (int i = 0; i < int'(FIFO_D); i++) begin
        fifo_addr_q[i] <= fifo_addr_d[i];
        fifo_data_q[i] <= fifo_data_d[i];
      end
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < int'(NREG); i++) regs_flat[i*REG_W +: REG_W] = regs_q[i];
  end

  assign core_gnt    = (state_q == S_CORE_ACK);
  assign core_rdata  = core_rdata_q;
  assign wr_evt      = wr_evt_q;
  assign wr_evt_src  = wr_evt_src_q;
  assign wr_evt_addr = wr_evt_addr_q;
  assign spi_ovf     = spi_ovf_q;
  assign busy        = spi_cand || core_gnt || core_req;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench for spi_reg_arbiter with a 6-register bank (addresses 6 and 7 out of range).
module tb_spi_reg_arbiter;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned REG_W  = 8;
  localparam int unsigned NREG   = 6;

  logic                  clk, rst;
  logic [ADDR_W-1:0]     spi_addr;
  logic [REG_W-1:0]      spi_wdata;
  logic                  spi_wvld;
  logic [REG_W-1:0]      spi_rdata;
  logic                  core_req, core_we;
  logic [ADDR_W-1:0]     core_addr;
  logic [REG_W-1:0]      core_wdata;
  logic                  core_gnt;
  logic [REG_W-1:0]      core_rdata;
  logic [NREG*REG_W-1:0] regs_flat;
  logic                  wr_evt, wr_evt_src;
  logic [ADDR_W-1:0]     wr_evt_addr;
  logic                  spi_ovf, busy;

  int checks = 0;
  int errors = 0;
  int n_spi_evt = 0;
  int n_core_evt = 0;
  int n_gnt = 0;
  int s_spi, s_gnt;

  spi_reg_arbiter #(.ADDR_W(ADDR_W), .REG_W(REG_W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wvld(spi_wvld), .spi_rdata(spi_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .regs_flat(regs_flat),
    .wr_evt(wr_evt), .wr_evt_src(wr_evt_src), .wr_evt_addr(wr_evt_addr),
    .spi_ovf(spi_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event tallies used to confirm how many commits/grants a sequence produced.
  always @(negedge clk) begin
    if (wr_evt) begin
      if (wr_evt_src) n_core_evt++;
      else            n_spi_evt++;
    end
    if (core_gnt) n_gnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wvld = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    step(); step();
    chk("rst_regs",   64'(regs_flat), 64'(0));
    chk("rst_gnt",    64'(core_gnt), 64'(0));
    chk("rst_evt",    64'(wr_evt), 64'(0));
    chk("rst_src",    64'(wr_evt_src), 64'(0));
    chk("rst_addr",   64'(wr_evt_addr), 64'(0));
    chk("rst_ovf",    64'(spi_ovf), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_rdata",  64'(core_rdata), 64'(0));
    rst = 1'b0;
    step();

    // SPI write reg3 = A5: event two cycles after the strobe
    spi_addr = 3'd3; spi_wdata = 8'hA5; spi_wvld = 1'b1;
    step(); spi_wvld = 1'b0;
    chk("spi_evt_t1",  64'(wr_evt), 64'(0));
    chk("spi_busy_t1", 64'(busy), 64'(1));
    step();
    chk("spi_evt_t2",  64'(wr_evt), 64'(1));
    chk("spi_src",     64'(wr_evt_src), 64'(0));
    chk("spi_addr",    64'(wr_evt_addr), 64'(3));
    chk("spi_rdata",   64'(spi_rdata), 64'(8'hA5));
    chk("spi_flat",    64'(regs_flat[31:24]), 64'(8'hA5));
    step();
    chk("spi_evt_off", 64'(wr_evt), 64'(0));
    chk("spi_idle",    64'(busy), 64'(0));

    // Core write reg5 = 3C then read it back
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'h3C;
    step();
    chk("cw_gnt",  64'(core_gnt), 64'(1));
    chk("cw_evt",  64'(wr_evt), 64'(1));
    chk("cw_src",  64'(wr_evt_src), 64'(1));
    chk("cw_addr", 64'(wr_evt_addr), 64'(5));
    core_req = 1'b0;
    step();
    chk("cw_gnt_off", 64'(core_gnt), 64'(0));
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd5;
    step();
    chk("cr_gnt",   64'(core_gnt), 64'(1));
    chk("cr_rdata", 64'(core_rdata), 64'(8'h3C));
    chk("cr_noevt", 64'(wr_evt), 64'(0));
    core_req = 1'b0;
    step();
    chk("cr_hold",  64'(core_rdata), 64'(8'h3C));
    chk("cr_gnt0",  64'(core_gnt), 64'(0));

    // Contention on reg1: SPI head and core write both candidates, core won last
    spi_addr = 3'd1; spi_wdata = 8'h11; spi_wvld = 1'b1;
    step(); spi_wvld = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd1; core_wdata = 8'h22;
    step();
    chk("ct_wait",  64'(core_gnt), 64'(0));
    chk("ct_evt0",  64'(wr_evt), 64'(1));
    chk("ct_src0",  64'(wr_evt_src), 64'(0));
    chk("ct_addr0", 64'(wr_evt_addr), 64'(1));
    step();
    chk("ct_gnt",   64'(core_gnt), 64'(1));
    chk("ct_evt1",  64'(wr_evt), 64'(1));
    chk("ct_src1",  64'(wr_evt_src), 64'(1));
    core_req = 1'b0;
    step();
    chk("ct_reg1",  64'(regs_flat[15:8]), 64'(8'h22));
    step();

    // Three back-to-back strobes under continuous core reads
    s_spi = n_spi_evt; s_gnt = n_gnt;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd0;
    spi_wvld = 1'b1; spi_addr = 3'd0; spi_wdata = 8'hA0;
    step(); spi_addr = 3'd2; spi_wdata = 8'hB2;
    step(); spi_addr = 3'd4; spi_wdata = 8'hC4;
    step(); spi_wvld = 1'b0;
    step();
    step();
    chk("bb_gnt3", 64'(core_gnt), 64'(1));
    core_req = 1'b0;
    step(); step(); step();
    chk("bb_nspi", 64'(n_spi_evt - s_spi), 64'(3));
    chk("bb_ngnt", 64'(n_gnt - s_gnt), 64'(3));
    chk("bb_ovf",  64'(spi_ovf), 64'(0));
    chk("bb_reg0", 64'(regs_flat[7:0]), 64'(8'hA0));
    chk("bb_reg2", 64'(regs_flat[23:16]), 64'(8'hB2));
    chk("bb_reg4", 64'(regs_flat[39:32]), 64'(8'hC4));
    step();

    // Five strobes under contention: the fifth finds the FIFO full without a pop
    s_spi = n_spi_evt;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd0;
    spi_wvld = 1'b1; spi_addr = 3'd0; spi_wdata = 8'h50;
    step(); spi_addr = 3'd1; spi_wdata = 8'h51;
    step(); spi_addr = 3'd2; spi_wdata = 8'h52;
    step(); spi_addr = 3'd3; spi_wdata = 8'h53;
    step(); spi_addr = 3'd4; spi_wdata = 8'h54;
    chk("of_pre", 64'(spi_ovf), 64'(0));
    step();
    chk("of_set", 64'(spi_ovf), 64'(1));
    chk("of_gnt", 64'(core_gnt), 64'(1));
    spi_wvld = 1'b0; core_req = 1'b0;
    step(); step(); step(); step();
    chk("of_sticky", 64'(spi_ovf), 64'(1));
    chk("of_nspi",   64'(n_spi_evt - s_spi), 64'(4));
    chk("of_bank",   64'(regs_flat), 64'(48'h3CC453525150));

    // Out-of-range core write/read at address 6
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd6; core_wdata = 8'hEE;
    step();
    chk("oor_wgnt", 64'(core_gnt), 64'(1));
    core_req = 1'b0;
    step();
    chk("oor_bank", 64'(regs_flat), 64'(48'h3CC453525150));
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd6;
    step();
    chk("oor_rgnt",  64'(core_gnt), 64'(1));
    chk("oor_rdata", 64'(core_rdata), 64'(0));
    core_req = 1'b0; spi_addr = 3'd7;
    #1;
    chk("oor_spi", 64'(spi_rdata), 64'(0));
    step();

    // Reset mid-flight: FIFO holds two entries, core request held
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd0;
    spi_wvld = 1'b1; spi_addr = 3'd1; spi_wdata = 8'h71;
    step(); spi_addr = 3'd2; spi_wdata = 8'h72;
    step(); spi_addr = 3'd3; spi_wdata = 8'h73;
    step(); spi_wvld = 1'b0;
    chk("mr_pre_gnt", 64'(core_gnt), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mr_regs",  64'(regs_flat), 64'(0));
    chk("mr_gnt",   64'(core_gnt), 64'(0));
    chk("mr_evt",   64'(wr_evt), 64'(0));
    chk("mr_ovf",   64'(spi_ovf), 64'(0));
    chk("mr_rdata", 64'(core_rdata), 64'(0));
    chk("mr_busy",  64'(busy), 64'(1));
    s_spi = n_spi_evt;
    step(); step();
    chk("mr_hold_gnt",  64'(core_gnt), 64'(0));
    chk("mr_hold_regs", 64'(regs_flat), 64'(0));
    rst = 1'b0;
    step();
    chk("mr_regnt", 64'(core_gnt), 64'(1));
    chk("mr_noevt", 64'(wr_evt), 64'(0));
    core_req = 1'b0;
    step(); step(); step();
    chk("mr_regs_after", 64'(regs_flat), 64'(0));
    chk("mr_nspi",       64'(n_spi_evt - s_spi), 64'(0));
    chk("mr_idle",       64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
